startup_gen: RTL and testbench



---
 rtl/startup_gen.sv | 144 ++++++++++++++
 tb/tb_startup_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/startup_gen.sv
// startup_gen: open-loop startup oscillator driving `gen` until resonant feedback takes over.
// Latency: `gen`/`busy` go high one clock after `en` is sampled high; each level lasts `hp_cur` clocks.
// Shutdown: a high half always completes before stopping; a low half is abandoned. Optional macro: STARTUP_GEN_FB_TRACK_EN.
module startup_gen #(
  parameter int CLK_MHZ = 100,
  parameter int F_KHZ   = 200,
  parameter int HP_MIN  = 100,
  parameter int HP_MAX  = 500,
  localparam int HP_DEFAULT = CLK_MHZ * 500 / F_KHZ,
  localparam int HPW        = $clog2(HP_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           fb,
  output logic           gen,
  output logic           busy,
  output logic [HPW-1:0] hp_cur
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [HPW-1:0] HP_DEF = HPW'(HP_DEFAULT);

  logic [1:0]     state;
  logic [HPW-1:0] hp_cnt;
  // Half-period that a burst starting this cycle will use.
  logic [HPW-1:0] hp_next;

`ifdef STARTUP_GEN_FB_TRACK_EN
  // Counter spans one full fb period and saturates just above the accepted range.
  localparam int MW = $clog2(2 * HP_MAX + 2);
  localparam logic [MW-1:0] M_SAT   = MW'(2 * HP_MAX + 1);
  localparam logic [MW:0]   LEN_MIN = (MW + 1)'(2 * HP_MIN);
  localparam logic [MW:0]   LEN_MAX = (MW + 1)'(2 * HP_MAX);

  logic           fb_q;
  logic [MW-1:0]  m_cnt;
  logic [MW:0]    m_len;
  logic [HPW-1:0] meas;
  logic           meas_vld;
  logic [HPW-1:0] hp_q;
  logic           unused_len;

  // The cycle carrying the falling edge closes the period, so it is counted too.
  assign m_len      = {1'b0, m_cnt} + 1'b1;
  assign unused_len = ^{m_len[MW], m_len[0]};
  assign hp_next    = meas_vld ? meas : hp_q;
  assign hp_cur     = hp_q;

  // Measure fb period between falling edges; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q     <= 1'b0;
      m_cnt    <= '0;
      meas     <= HP_DEF;
      meas_vld <= 1'b0;
    end else begin
      fb_q <= fb;
      if (fb_q && !fb) begin
        m_cnt <= '0;
        if (m_len >= LEN_MIN && m_len <= LEN_MAX) begin
          meas     <= m_len[HPW:1];
          meas_vld <= 1'b1;
        end else begin
          meas_vld <= 1'b0;
        end
      end else if (m_cnt != M_SAT) begin
        m_cnt <= m_cnt + 1'b1;
      end
    end
  end

  // Retune only at burst start so the period never changes mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q <= HP_DEF;
    end else if (state == IDLE && en && meas_vld) begin
      hp_q <= meas;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = fb ^ (HP_MIN > HP_MAX);
  assign hp_next    = HP_DEF;
  assign hp_cur     = HP_DEF;
`endif

  assign busy = (state != IDLE);

  // Burst sequencer: half-period counter, output toggling and clean shutdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gen    <= 1'b0;
      hp_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          gen <= 1'b0;
          if (en) begin
            state  <= RUN;
            gen    <= 1'b1;
            hp_cnt <= hp_next - 1'b1;
          end
        end
        RUN: begin
          // Counting continues on the stop cycle so the last high half stays full length;
          // a toggle on that same cycle happens first and FINISH sees the new level.
          if (hp_cnt == '0) begin
            gen    <= ~gen;
            hp_cnt <= hp_cur - 1'b1;
          end else begin
            hp_cnt <= hp_cnt - 1'b1;
          end
          if (!en) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          // Complete a high half; a low half ends immediately. `en` is ignored here.
          if (gen) begin
            if (hp_cnt == '0) begin
              gen   <= 1'b0;
              state <= IDLE;
            end else begin
              hp_cnt <= hp_cnt - 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gen   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_startup_gen.sv
// tb_startup_gen: directed vectors for the startup oscillator.
// Vectors hold `en` for a number of clocks, then compare `gen`/`busy` 1 ns after the edge.
// Feedback-tracking sequences are compiled only with STARTUP_GEN_FB_TRACK_EN.
module tb_startup_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       fb = 1'b0;
  logic       gen;
  logic       busy;
  logic [8:0] hp_cur;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic en;
    int   cycles;
    logic gen;
    logic busy;
  } vec_t;

  vec_t vecs[19];

  startup_gen dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .fb     (fb),
    .gen    (gen),
    .busy   (busy),
    .hp_cur (hp_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fb_periods(input int period, input int n);
    for (int i = 0; i < n; i++) begin
      fb = 1'b1;
      step(period / 2);
      fb = 1'b0;
      step(period / 2);
    end
  endtask

  initial begin
    // Default half-period 250.
    vecs[0]  = '{1'b1,   1, 1'b1, 1'b1};  // gen rises one clock after en
    vecs[1]  = '{1'b1, 249, 1'b1, 1'b1};  // still in first high half
    vecs[2]  = '{1'b1,   1, 1'b0, 1'b1};  // toggles after 250 clocks
    vecs[3]  = '{1'b1, 249, 1'b0, 1'b1};
    vecs[4]  = '{1'b1,   1, 1'b1, 1'b1};  // period 500
    vecs[5]  = '{1'b1,  99, 1'b1, 1'b1};  // 100 clocks into high half
    vecs[6]  = '{1'b0,   1, 1'b1, 1'b1};  // en drop: FINISH, stays high
    vecs[7]  = '{1'b0, 148, 1'b1, 1'b1};
    vecs[8]  = '{1'b0,   1, 1'b1, 1'b1};  // last high clock
    vecs[9]  = '{1'b0,   1, 1'b0, 1'b0};  // gen and busy fall together
    vecs[10] = '{1'b1,   1, 1'b1, 1'b1};  // new burst
    vecs[11] = '{1'b1, 250, 1'b0, 1'b1};  // into low half
    vecs[12] = '{1'b1,  10, 1'b0, 1'b1};
    vecs[13] = '{1'b0,   1, 1'b0, 1'b1};  // drop during low half
    vecs[14] = '{1'b1,   1, 1'b0, 1'b0};  // re-raise in FINISH ignored; IDLE
    vecs[15] = '{1'b1,   1, 1'b1, 1'b1};  // now in IDLE: burst starts
    vecs[16] = '{1'b1, 249, 1'b1, 1'b1};  // counter at 0
    vecs[17] = '{1'b0,   1, 1'b0, 1'b1};  // toggle first, then FINISH on low
    vecs[18] = '{1'b0,   1, 1'b0, 1'b0};  // IDLE next clock

    // Reset state.
    #2;
    check("rst_gen", gen, 0);
    check("rst_busy", busy, 0);
    check("rst_hp", hp_cur, 250);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("idle_gen", gen, 0);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 19; i++) begin
      en = vecs[i].en;
      step(vecs[i].cycles);
      check($sformatf("vec%0d_gen", i), gen, vecs[i].gen);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end
    check("hp_default", hp_cur, 250);

    // Asynchronous reset in the middle of a high half.
    en = 1'b1;
    step(51);
    check("pre_rst_gen", gen, 1);
    rst_n = 1'b0;
    #1;
    check("arst_gen", gen, 0);
    check("arst_busy", busy, 0);
    check("arst_hp", hp_cur, 250);
    en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_rst_gen", gen, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_hp", hp_cur, 250);
    en = 1'b1;
    step(1);
    check("post_rst_start", gen, 1);
    step(249);
    check("post_rst_high", gen, 1);
    step(1);
    check("post_rst_low", gen, 0);
    en = 1'b0;
    step(2);
    check("post_rst_idle", busy, 0);

`ifdef STARTUP_GEN_FB_TRACK_EN
    // fb period 400 -> half-period 200 at next burst start.
    fb_periods(400, 3);
    check("trk_hp_idle", hp_cur, 250);
    en = 1'b1;
    step(1);
    check("trk_hp200", hp_cur, 200);
    check("trk_start", gen, 1);
    step(199);
    check("trk_high199", gen, 1);
    step(1);
    check("trk_low200", gen, 0);
    // fb period changes mid-burst: hp_cur must hold.
    fb_periods(300, 2);
    check("trk_mid_hp", hp_cur, 200);
    check("trk_mid_gen", gen, 1);
    en = 1'b0;
    step(250);
    check("trk_stop_busy", busy, 0);
    en = 1'b1;
    step(1);
    check("trk_hp150", hp_cur, 150);
    step(149);
    check("trk_high149", gen, 1);
    step(1);
    check("trk_low150", gen, 0);
    en = 1'b0;
    step(2);
    check("trk_idle2", busy, 0);
    // Out-of-range period clears valid; hp_cur keeps its prior value.
    fb_periods(1200, 2);
    en = 1'b1;
    step(1);
    check("trk_oor_hp", hp_cur, 150);
    check("trk_oor_gen", gen, 1);
    en = 1'b0;
    step(200);
    check("trk_oor_idle", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
